// File: rtl/mc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_sequencer : multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
// Revision     : 1.0
// ---------------------------------------------------------------------------
module mc_sequencer #(
  parameter int MAX_INSTR = 43,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic [31:0]      ins,
  input  logic             zero,
  output logic             int_load,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             mem2reg,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             beq,
  output logic             j,
  output logic [2:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_MEM    = 3'd5;
  localparam logic [2:0] S_WB     = 3'd6;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      MAX_W   = MAX_INSTR;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             is_rtype;
  logic             is_beq;
  logic             is_lw;
  logic             is_sw;
  logic             exec_op;
  logic             uses_imm;
  logic             retire;
  logic             budget_hit;
  logic             start_run;
  logic [CNT_W-1:0] count_inc;
  logic [2:0]       alu_sel;
  logic             unused_bits;

  // Datapath-owned fields and the zero flag are not needed for sequencing.
  assign unused_bits = ^{ins[25:6], zero};

  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_beq    = (opcode == OP_BEQ);
  assign is_lw     = (opcode == OP_LW);
  assign is_sw     = (opcode == OP_SW);
  assign exec_op   = is_rtype | is_beq | is_lw | is_sw | (opcode == OP_ADDI);
  assign uses_imm  = ~(is_rtype | is_beq);
  assign start_run = start && ((state == S_IDLE) || (state == S_HALT));

  assign retire = ((state == S_DECODE) && (opcode == OP_J)) ||
                  ((state == S_EXEC)   && is_beq)            ||
                  ((state == S_MEM)    && is_sw)             ||
                  (state == S_WB);

  // Saturating count; the budget compare is done at 32 bits so a budget
  // beyond the counter range simply never matches.
  assign count_inc  = (instr_count == CNT_MAX) ? instr_count : instr_count + CNT_ONE;
  assign budget_hit = (32'(count_inc) == MAX_W);

  always_comb begin
    alu_sel = ALU_ADD;
    if (is_rtype) begin
      case (funct)
        FN_OR:   alu_sel = ALU_OR;
        FN_AND:  alu_sel = ALU_AND;
        FN_SUB:  alu_sel = ALU_SUB;
        FN_SLT:  alu_sel = ALU_SLT;
        default: alu_sel = ALU_ADD;
      endcase
    end else if (is_beq) begin
      alu_sel = ALU_SUB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_INIT;
      S_INIT:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_J) state_nxt = S_FETCH;
        else if (exec_op)   state_nxt = S_EXEC;
        else                state_nxt = S_HALT;
      end
      S_EXEC: begin
        if (is_beq)             state_nxt = S_FETCH;
        else if (is_lw | is_sw) state_nxt = S_MEM;
        else                    state_nxt = S_WB;
      end
      S_MEM:    state_nxt = is_lw ? S_WB : S_FETCH;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   if (start) state_nxt = S_INIT;
      default:  state_nxt = S_IDLE;
    endcase
    if (retire && (budget_hit || halt_req)) state_nxt = S_HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode      <= 6'd0;
      funct       <= 6'd0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      if (state == S_FETCH) begin
        opcode <= ins[31:26];
        funct  <= ins[5:0];
      end
      if (start_run) begin
        done        <= 1'b0;
        illegal     <= 1'b0;
        instr_count <= '0;
      end
      if (retire) begin
        instr_count <= count_inc;
        if (budget_hit || halt_req) done <= 1'b1;
      end
      if ((state == S_DECODE) && !exec_op && (opcode != OP_J)) illegal <= 1'b1;
    end
  end

  always_comb begin
    int_load  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    reg_dst   = 1'b0;
    alu_src   = 1'b0;
    mem2reg   = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    beq       = 1'b0;
    j         = 1'b0;
    alu_op    = 3'b000;
    busy      = 1'b0;
    case (state)
      S_INIT: begin
        busy     = 1'b1;
        int_load = 1'b1;
        pc_we    = 1'b1;
      end
      S_FETCH: begin
        busy  = 1'b1;
        ir_we = 1'b1;
      end
      S_DECODE: begin
        busy = 1'b1;
        if (opcode == OP_J) begin
          j     = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_EXEC: begin
        busy    = 1'b1;
        alu_src = uses_imm;
        alu_op  = alu_sel;
        if (is_beq) begin
          beq   = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_MEM: begin
        busy      = 1'b1;
        alu_src   = uses_imm;
        alu_op    = alu_sel;
        mem_read  = is_lw;
        mem_write = is_sw;
        pc_we     = is_sw;
      end
      S_WB: begin
        busy      = 1'b1;
        alu_src   = uses_imm;
        alu_op    = alu_sel;
        reg_write = 1'b1;
        pc_we     = 1'b1;
        reg_dst   = is_rtype;
        mem2reg   = is_lw;
        mem_read  = is_lw;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mc_sequencer : directed self-checking bench for mc_sequencer
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic [31:0] ins;
  logic        zero;
  logic        int_load, ir_we, pc_we, reg_dst, alu_src, mem2reg;
  logic        reg_write, mem_read, mem_write, beq, j, busy, done, illegal;
  logic [2:0]  alu_op;
  logic [7:0]  instr_count;
  logic [14:0] ctl;

  int errors = 0;
  int checks = 0;

  localparam logic [14:0] C_IL   = 15'h4000;
  localparam logic [14:0] C_IR   = 15'h2000;
  localparam logic [14:0] C_PC   = 15'h1000;
  localparam logic [14:0] C_RD   = 15'h0800;
  localparam logic [14:0] C_AS   = 15'h0400;
  localparam logic [14:0] C_M2R  = 15'h0200;
  localparam logic [14:0] C_RW   = 15'h0100;
  localparam logic [14:0] C_MR   = 15'h0080;
  localparam logic [14:0] C_MW   = 15'h0040;
  localparam logic [14:0] C_BQ   = 15'h0020;
  localparam logic [14:0] C_J    = 15'h0010;
  localparam logic [14:0] A_001  = 15'h0002;
  localparam logic [14:0] A_010  = 15'h0004;
  localparam logic [14:0] A_110  = 15'h000C;
  localparam logic [14:0] C_BUSY = 15'h0001;

  localparam logic [14:0] E_INIT = C_IL | C_PC | C_BUSY;
  localparam logic [14:0] E_F    = C_IR | C_BUSY;
  localparam logic [14:0] E_D    = C_BUSY;

  localparam logic [31:0] I_OR   = 32'h00A41825;
  localparam logic [31:0] I_LW   = 32'h8C080004;
  localparam logic [31:0] I_SW   = 32'hAC080008;
  localparam logic [31:0] I_BEQ  = 32'h11090003;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_ADDI = 32'h20080001;
  localparam logic [31:0] I_BAD  = 32'hFC000000;

  assign ctl = {int_load, ir_we, pc_we, reg_dst, alu_src, mem2reg, reg_write,
                mem_read, mem_write, beq, j, alu_op, busy};

  mc_sequencer #(.MAX_INSTR(43), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .ins(ins),
    .zero(zero), .int_load(int_load), .ir_we(ir_we), .pc_we(pc_we),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem2reg(mem2reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .beq(beq), .j(j), .alu_op(alu_op), .busy(busy), .done(done),
    .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [14:0] exp);
    tick();
    chk(tag, {17'd0, ctl}, {17'd0, exp});
  endtask

  int n, pc_n, ir_n, rw_n, ovl;

  initial begin
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; ins = 32'd0; zero = 1'b0;
    repeat (2) tick();
    chk("rst_ctl", {17'd0, ctl}, 32'd0);
    chk("rst_flags", {30'd0, done, illegal}, 32'd0);
    chk("rst_cnt", {24'd0, instr_count}, 32'd0);
    rst_n = 1'b1;
    cyc("idle_wait", 15'd0);

    // R-type OR
    start = 1'b1;
    cyc("init", E_INIT);
    start = 1'b0;
    cyc("r_fetch", E_F);  ins = I_OR;
    cyc("r_dec", E_D);
    cyc("r_ex", C_BUSY | A_001);
    cyc("r_wb", C_BUSY | A_001 | C_RD | C_RW | C_PC);

    // lw (start pulse while busy must be ignored)
    cyc("lw_fetch", E_F);
    chk("cnt_after_r", {24'd0, instr_count}, 32'd1);
    ins = I_LW;
    cyc("lw_dec", E_D);
    cyc("lw_ex", C_BUSY | C_AS | A_010);
    start = 1'b1;
    cyc("lw_mem", C_BUSY | C_AS | A_010 | C_MR);
    start = 1'b0;
    cyc("lw_wb", C_BUSY | C_AS | A_010 | C_MR | C_M2R | C_RW | C_PC);

    // sw
    cyc("sw_fetch", E_F);
    chk("cnt_after_lw", {24'd0, instr_count}, 32'd2);
    ins = I_SW;
    cyc("sw_dec", E_D);
    cyc("sw_ex", C_BUSY | C_AS | A_010);
    cyc("sw_mem", C_BUSY | C_AS | A_010 | C_MW | C_PC);

    // beq with zero=1 then zero=0
    cyc("beq1_fetch", E_F);
    chk("cnt_after_sw", {24'd0, instr_count}, 32'd3);
    ins = I_BEQ; zero = 1'b1;
    cyc("beq1_dec", E_D);
    cyc("beq1_ex", C_BUSY | A_110 | C_BQ | C_PC);
    cyc("beq0_fetch", E_F);
    zero = 1'b0;
    cyc("beq0_dec", E_D);
    cyc("beq0_ex", C_BUSY | A_110 | C_BQ | C_PC);

    // j
    cyc("j_fetch", E_F);
    chk("cnt_after_beq", {24'd0, instr_count}, 32'd5);
    ins = I_J;
    cyc("j_dec", E_D | C_J | C_PC);

    // halt_req pulse confined to EXEC is ignored
    cyc("h1_fetch", E_F);
    chk("cnt_after_j", {24'd0, instr_count}, 32'd6);
    ins = I_ADDI;
    cyc("h1_dec", E_D);
    cyc("h1_ex", C_BUSY | C_AS | A_010);
    halt_req = 1'b1;
    cyc("h1_wb", C_BUSY | C_AS | A_010 | C_RW | C_PC);
    halt_req = 1'b0;
    cyc("h1_next_fetch", E_F);
    chk("h1_done", {31'd0, done}, 32'd0);
    chk("h1_cnt", {24'd0, instr_count}, 32'd7);

    // halt_req held through WB halts after that retire
    cyc("h2_dec", E_D);
    cyc("h2_ex", C_BUSY | C_AS | A_010);
    halt_req = 1'b1;
    cyc("h2_wb", C_BUSY | C_AS | A_010 | C_RW | C_PC);
    cyc("h2_halt", 15'd0);
    halt_req = 1'b0;
    chk("h2_done", {31'd0, done}, 32'd1);
    chk("h2_cnt", {24'd0, instr_count}, 32'd8);
    cyc("h2_halt_hold", 15'd0);

    // fresh run, then illegal opcode after one addi
    start = 1'b1;
    cyc("ill_init", E_INIT);
    start = 1'b0;
    chk("restart_clr", {23'd0, done, illegal, instr_count}, 32'd0);
    cyc("ill_a_fetch", E_F);  ins = I_ADDI;
    cyc("ill_a_dec", E_D);
    cyc("ill_a_ex", C_BUSY | C_AS | A_010);
    cyc("ill_a_wb", C_BUSY | C_AS | A_010 | C_RW | C_PC);
    cyc("ill_fetch", E_F);  ins = I_BAD;
    cyc("ill_dec", E_D);
    cyc("ill_halt", 15'd0);
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_done", {31'd0, done}, 32'd0);
    chk("ill_cnt", {24'd0, instr_count}, 32'd1);

    // budget: 43 addi instructions
    start = 1'b1;
    cyc("bud_init", E_INIT);
    start = 1'b0;
    chk("bud_ill_clr", {31'd0, illegal}, 32'd0);
    ins = I_ADDI;
    n = 0; pc_n = 1; ir_n = 0; rw_n = 0; ovl = 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
      pc_n += int'(pc_we);
      ir_n += int'(ir_we);
      rw_n += int'(reg_write);
      ovl  += int'(ir_we & (pc_we | reg_write | mem_write));
      if (n == 169) begin
        chk("bud_cnt42", {24'd0, instr_count}, 32'd42);
        chk("bud_not_done", {31'd0, done}, 32'd0);
      end
    end
    chk("bud_cycles", n, 32'd173);
    chk("bud_cnt", {24'd0, instr_count}, 32'd43);
    chk("bud_busy", {31'd0, busy}, 32'd0);
    chk("bud_pc_pulses", pc_n, 32'd44);
    chk("bud_ir_pulses", ir_n, 32'd43);
    chk("bud_rw_pulses", rw_n, 32'd43);
    chk("bud_overlap", ovl, 32'd0);
    repeat (3) cyc("bud_quiet", 15'd0);

    // async reset mid-MEM
    start = 1'b1;
    cyc("r_init", E_INIT);
    start = 1'b0;
    cyc("r_a_fetch", E_F);  ins = I_ADDI;
    cyc("r_a_dec", E_D);
    cyc("r_a_ex", C_BUSY | C_AS | A_010);
    cyc("r_a_wb", C_BUSY | C_AS | A_010 | C_RW | C_PC);
    cyc("r_lw_fetch", E_F);  ins = I_LW;
    cyc("r_lw_dec", E_D);
    cyc("r_lw_ex", C_BUSY | C_AS | A_010);
    cyc("r_lw_mem", C_BUSY | C_AS | A_010 | C_MR);
    chk("r_cnt_before", {24'd0, instr_count}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("r_async_ctl", {17'd0, ctl}, 32'd0);
    chk("r_async_cnt", {24'd0, instr_count}, 32'd0);
    chk("r_async_flags", {30'd0, done, illegal}, 32'd0);
    tick();
    rst_n = 1'b1;
    cyc("r_idle", 15'd0);
    cyc("r_idle2", 15'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
